// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : load_store_unit                                               |
// | Purpose  : Connects the RV32I execute stage to a word-wide data memory.  |
// |            Loads: byte/half lane extraction with sign or zero extension. |
// |            SW: single-cycle write.                                       |
// |            SB/SH: two-cycle read-modify-write with one stall cycle.      |
// |            Misaligned, out-of-range and illegal accesses raise fault.    |
// | Ports    : clk, rst_n (sync, active low)                                 |
// |            req/we/funct3/addr/wdata : request from the core              |
// |            rdata/stall/fault/fault_sticky : response to the core         |
// |            mem_A/mem_WD/mem_WE/mem_RD : word memory, comb read           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module load_store_unit #(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        fault,
   output logic        fault_sticky,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   output logic        mem_WE,
   input  logic [31:0] mem_RD
);

   localparam logic [0:0]  S_IDLE = 1'b0;
   localparam logic [0:0]  S_RMW  = 1'b1;

   localparam logic [2:0]  c_F_B  = 3'b000;
   localparam logic [2:0]  c_F_H  = 3'b001;
   localparam logic [2:0]  c_F_W  = 3'b010;
   localparam logic [2:0]  c_F_BU = 3'b100;
   localparam logic [2:0]  c_F_HU = 3'b101;

   localparam logic [31:0] c_MEM_WORDS = 32'(MEM_WORDS);

   logic [0:0]  r_state;
   logic [0:0]  w_next_state;
   logic [31:0] r_merged;
   logic [31:0] r_addr;
   logic        r_fault_sticky;

   logic        w_misaligned;
   logic        w_illegal;
   logic        w_out_of_range;
   logic        w_fault;
   logic        w_is_load;
   logic        w_is_sw;
   logic        w_is_sub_store;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic [31:0] w_merged;

   // ---------------------------------------------------------------- decode
   always_comb begin
      w_misaligned = 1'b0;
      w_illegal    = 1'b0;
      case (funct3)
         c_F_B  : begin end
         c_F_H  : w_misaligned = addr[0];
         c_F_W  : w_misaligned = (addr[1:0] != 2'b00);
         c_F_BU : w_illegal    = we;                      // no unsigned stores
         c_F_HU : begin
            w_misaligned = addr[0];
            w_illegal    = we;
         end
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_out_of_range = ({2'b00, addr[31:2]} >= c_MEM_WORDS);

   // Faults are only meaningful for a live request seen in IDLE; the RMW
   // cycle ignores the core inputs entirely.
   assign w_fault        = req & (r_state == S_IDLE) &
                           (w_misaligned | w_illegal | w_out_of_range);
   assign w_is_load      = req & ~we & ~w_fault & (r_state == S_IDLE);
   assign w_is_sw        = req &  we & ~w_fault & (r_state == S_IDLE) & (funct3 == c_F_W);
   assign w_is_sub_store = req &  we & ~w_fault & (r_state == S_IDLE) & (funct3 != c_F_W);

   // ------------------------------------------------ lane extract / merge
   assign w_byte = mem_RD[{addr[1:0], 3'b000} +: 8];
   assign w_half = addr[1] ? mem_RD[31:16] : mem_RD[15:0];

   always_comb begin
      w_load_data = 32'h0000_0000;
      case (funct3)
         c_F_B  : w_load_data = {{24{w_byte[7]}}, w_byte};
         c_F_H  : w_load_data = {{16{w_half[15]}}, w_half};
         c_F_W  : w_load_data = mem_RD;
         c_F_BU : w_load_data = {24'h00_0000, w_byte};
         c_F_HU : w_load_data = {16'h0000, w_half};
         default: w_load_data = 32'h0000_0000;
      endcase
   end

   // funct3[0] distinguishes SH from SB once SW has been excluded.
   always_comb begin
      w_merged = mem_RD;
      if (funct3[0]) begin
         w_merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      end else begin
         w_merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
      end
   end

   // --------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE : if (w_is_sub_store) w_next_state = S_RMW;
         S_RMW  : w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // ------------------------------------------------------- datapath regs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_merged       <= 32'h0000_0000;
         r_addr         <= 32'h0000_0000;
         r_fault_sticky <= 1'b0;
      end else begin
         if (w_is_sub_store) begin
            r_merged <= w_merged;
            r_addr   <= {addr[31:2], 2'b00};
         end
         if (w_fault) begin
            r_fault_sticky <= 1'b1;
         end
      end
   end

   assign fault_sticky = r_fault_sticky;

   // ---------------------------------------------------------------- outputs
   always_comb begin
      mem_A  = {addr[31:2], 2'b00};
      mem_WD = wdata;
      mem_WE = 1'b0;
      stall  = 1'b0;
      rdata  = 32'h0000_0000;
      fault  = 1'b0;
      case (r_state)
         S_RMW: begin
            mem_A  = r_addr;
            mem_WD = r_merged;
            mem_WE = rst_n;        // reset during RMW aborts the write
         end
         default: begin
            fault = w_fault;
            if (rst_n) begin
               mem_WE = w_is_sw;
               stall  = w_is_sub_store;
            end
            if (w_is_load) begin
               rdata = w_load_data;
            end
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_load_store_unit                                            |
// | Purpose  : Self-checking bench for load_store_unit. Directed scenarios   |
// |            followed by random loads/stores/resets, compared against a    |
// |            reference memory image and byte-lane arithmetic model.        |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

   localparam int MEM_WORDS = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        stall;
   logic        fault;
   logic        fault_sticky;
   logic [31:0] mem_A;
   logic [31:0] mem_WD;
   logic        mem_WE;
   logic [31:0] mem_RD;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] ref_mem [MEM_WORDS];
   bit          ref_sticky = 1'b0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .we           (we),
      .funct3       (funct3),
      .addr         (addr),
      .wdata        (wdata),
      .rdata        (rdata),
      .stall        (stall),
      .fault        (fault),
      .fault_sticky (fault_sticky),
      .mem_A        (mem_A),
      .mem_WD       (mem_WD),
      .mem_WE       (mem_WE),
      .mem_RD       (mem_RD)
   );

   // Data memory: combinational read, clocked word write.
   logic [31:0] mem [MEM_WORDS];
   always_comb mem_RD = (mem_A[31:8] == 24'h0) ? mem[mem_A[7:2]] : 32'h0;
   always @(posedge clk) begin
      if (mem_WE && mem_A[31:8] == 24'h0) mem[mem_A[7:2]] <= mem_WD;
   end

   // ------------------------------------------------------------ checking
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------ reference model
   function automatic bit m_fault(bit r, bit w, logic [2:0] f, logic [31:0] a);
      int size;
      bit legal;
      if (!r) return 1'b0;
      size  = 1 << f[1:0];
      legal = (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5) && !(f[2] && w);
      if (!legal) return 1'b1;
      if ((a % size) != 0) return 1'b1;
      if ((a / 4) >= MEM_WORDS) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_load(logic [31:0] w, logic [2:0] f, logic [1:0] off);
      logic [31:0] sh;
      sh = w >> (8 * off);
      case (f)
         3'd0:    return {{24{sh[7]}}, sh[7:0]};
         3'd1:    return {{16{sh[15]}}, sh[15:0]};
         3'd4:    return {24'h0, sh[7:0]};
         3'd5:    return {16'h0, sh[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] m_merge(logic [31:0] w, logic [31:0] d, logic [2:0] f, logic [1:0] off);
      logic [31:0] mask;
      mask = (f[1:0] == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
      return (w & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
   endfunction

   // One core request; sub-word stores also cover the RMW cycle. With
   // abort set, reset is asserted in the RMW cycle instead.
   task automatic step(input bit r, input bit w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d, input bit abort_rmw);
      bit          flt, is_load, is_sw, is_sub;
      int          idx;
      logic [1:0]  off;
      logic [31:0] merged;
      @(negedge clk);
      rst_n = 1'b1; req = r; we = w; funct3 = f; addr = a; wdata = d;
      #1;
      flt     = m_fault(r, w, f, a);
      idx     = int'(a[31:2]);
      off     = a[1:0];
      is_load = r && !w && !flt;
      is_sw   = r && w && !flt && f == 3'd2;
      is_sub  = r && w && !flt && f != 3'd2;
      check("fault",  {31'h0, fault},        {31'h0, flt});
      check("sticky", {31'h0, fault_sticky}, {31'h0, ref_sticky});
      check("stall",  {31'h0, stall},        {31'h0, is_sub});
      check("mem_WE", {31'h0, mem_WE},       {31'h0, is_sw});
      check("mem_A",  mem_A,                 {a[31:2], 2'b00});
      if (is_load)      check("rdata", rdata, m_load(ref_mem[idx], f, off));
      else if (!w || !r || flt) check("rdata_zero", rdata, 32'h0);
      if (is_sw) begin
         check("sw_WD", mem_WD, d);
         ref_mem[idx] = d;
      end
      if (flt) ref_sticky = 1'b1;
      if (is_sub) begin
         merged = m_merge(ref_mem[idx], d, f, off);
         @(negedge clk);
         if (abort_rmw) begin
            rst_n = 1'b0;
            #1;
            check("abort_WE",    {31'h0, mem_WE}, 32'h0);
            check("abort_stall", {31'h0, stall},  32'h0);
            ref_sticky = 1'b0;
         end else begin
            // Core inputs are don't-care during RMW.
            req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
            funct3 = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;
            #1;
            check("rmw_WE",    {31'h0, mem_WE}, 32'h1);
            check("rmw_WD",    mem_WD,          merged);
            check("rmw_A",     mem_A,           {a[31:2], 2'b00});
            check("rmw_stall", {31'h0, stall},  32'h0);
            check("rmw_fault", {31'h0, fault},  32'h0);
            check("rmw_rdata", rdata,           32'h0);
            ref_mem[idx] = merged;
         end
      end
   endtask

   task automatic reset_cycle();
      @(negedge clk);
      rst_n = 1'b0; req = 1'b0;
      we = 1'($urandom_range(0, 1)); funct3 = 3'($urandom_range(0, 7));
      addr = $urandom; wdata = $urandom;
      #1;
      check("rst_stall", {31'h0, stall},  32'h0);
      check("rst_WE",    {31'h0, mem_WE}, 32'h0);
      check("rst_rdata", rdata,           32'h0);
      ref_sticky = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      bit          r, w;
      logic [2:0]  f;
      logic [31:0] a;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_stall",  {31'h0, stall},        32'h0);
      check("reset_WE",     {31'h0, mem_WE},       32'h0);
      check("reset_rdata",  rdata,                 32'h0);
      check("reset_sticky", {31'h0, fault_sticky}, 32'h0);

      // Fill memory through the DUT so both images agree.
      for (int i = 0; i < MEM_WORDS; i++) step(1, 1, 3'd2, 32'(i * 4), $urandom, 0);

      // SW then LW
      step(1, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
      step(1, 0, 3'd2, 32'h10, 32'h0, 0);
      // SB read-modify-write
      step(1, 1, 3'd2, 32'h20, 32'h11223344, 0);
      step(1, 1, 3'd0, 32'h22, 32'h000000AA, 0);
      step(1, 0, 3'd2, 32'h20, 32'h0, 0);
      // Sign / zero extension
      step(1, 1, 3'd2, 32'h0, 32'h80FF7F01, 0);
      step(1, 0, 3'd0, 32'h1, 32'h0, 0);
      step(1, 0, 3'd0, 32'h2, 32'h0, 0);
      step(1, 0, 3'd4, 32'h3, 32'h0, 0);
      step(1, 0, 3'd1, 32'h2, 32'h0, 0);
      step(1, 0, 3'd5, 32'h2, 32'h0, 0);
      // Faults
      step(1, 0, 3'd2, 32'h6,   32'h0, 0);
      step(1, 1, 3'd1, 32'h3,   32'h1234, 0);
      step(1, 1, 3'd2, 32'h100, 32'hCAFEF00D, 0);
      step(0, 0, 3'd0, 32'h0,   32'h0, 0);
      // Reset during RMW aborts the write
      step(1, 1, 3'd2, 32'h8, 32'h12345678, 0);
      step(1, 1, 3'd1, 32'h8, 32'h0000BEEF, 1);
      step(1, 0, 3'd2, 32'h8, 32'h0, 0);
      // Back-to-back byte stores
      step(1, 1, 3'd2, 32'h0, 32'h0, 0);
      step(1, 1, 3'd0, 32'h0, 32'hAA, 0);
      step(1, 1, 3'd0, 32'h1, 32'hBB, 0);
      step(1, 1, 3'd0, 32'h2, 32'hCC, 0);
      step(1, 1, 3'd0, 32'h3, 32'hDD, 0);
      step(1, 0, 3'd2, 32'h0, 32'h0, 0);
      check("b2b_word", ref_mem[0], 32'hDDCCBBAA);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 24) == 0) begin
            reset_cycle();
         end else begin
            r = ($urandom_range(0, 7) != 0);
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f = 3'($urandom_range(0, 7));
            else begin
               case ($urandom_range(0, 4))
                  0: f = 3'd0; 1: f = 3'd1; 2: f = 3'd2; 3: f = 3'd4; default: f = 3'd5;
               endcase
            end
            if ($urandom_range(0, 15) == 0) a = $urandom;
            else a = 32'(($urandom_range(0, MEM_WORDS + 5) << 2) | $urandom_range(0, 3));
            step(r, w, f, a, $urandom, 0);
         end
      end
      step(0, 0, 3'd0, 32'h0, 32'h0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
